// File: rtl/if_fetch_queue.sv
// Decoupled RV32I fetch front end: credit-limited sequential imem requests,
// in-order response capture into a circular fetch queue, redirect flushing.
module if_fetch_queue #(
  parameter logic [31:0] RESET_ADDR      = 32'h0000_0000,
  parameter int          FQ_DEPTH        = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_redirect,
  input  logic [31:0]                   i_redirect_target,
  output logic                          o_imem_req_valid,
  output logic [31:0]                   o_imem_req_addr,
  input  logic                          i_imem_req_ready,
  input  logic                          i_imem_resp_valid,
  input  logic [31:0]                   i_imem_resp_rdata,
  output logic                          o_inst_valid,
  output logic [31:0]                   o_inst,
  output logic [31:0]                   o_fetch_pc,
  output logic [31:0]                   o_pc_plus_4,
  input  logic                          i_id_ready,
  output logic [$clog2(FQ_DEPTH+1)-1:0] o_fq_count
);

  localparam int CW = $clog2(FQ_DEPTH + 1);
  localparam int PW = $clog2(FQ_DEPTH);
  localparam int IW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW = $clog2(FQ_DEPTH + MAX_OUTSTANDING + 1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   r_pc;
  logic [31:0]   r_respPc;
  logic [IW-1:0] r_inflight;
  logic [IW-1:0] r_dropCnt;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_rdPtr;
  logic [PW-1:0] r_wrPtr;
  logic [31:0]   r_qPc   [FQ_DEPTH];
  logic [31:0]   r_qInst [FQ_DEPTH];

  logic [IW-1:0] w_live;
  logic [SW-1:0] w_occupied;
  logic [IW-1:0] w_inflightNext;
  logic          w_reqValid;
  logic          w_accept;
  logic          w_headValid;
  logic          w_drop;
  logic          w_push;
  logic          w_pop;

  // A request is only issued if the queue can hold its word plus every live response.
  assign w_live         = r_inflight - r_dropCnt;
  assign w_occupied     = SW'(r_count) + SW'(w_live);
  assign w_reqValid     = i_rst_n && !i_redirect
                          && (r_inflight < IW'(MAX_OUTSTANDING))
                          && (w_occupied < SW'(FQ_DEPTH));
  assign w_accept       = w_reqValid && i_imem_req_ready;
  assign w_headValid    = (r_count != '0);
  assign w_drop         = i_imem_resp_valid && (i_redirect || (r_dropCnt != '0));
  assign w_push         = i_imem_resp_valid && !w_drop;
  assign w_pop          = w_headValid && i_id_ready && !i_redirect;
  assign w_inflightNext = r_inflight + IW'(w_accept) - IW'(i_imem_resp_valid);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc       <= RESET_ADDR;
      r_respPc   <= RESET_ADDR;
      r_inflight <= '0;
      r_dropCnt  <= '0;
      r_count    <= '0;
      r_rdPtr    <= '0;
      r_wrPtr    <= '0;
    end else if (i_redirect) begin
      // Everything still in flight after this cycle belongs to the old path.
      r_pc       <= i_redirect_target;
      r_respPc   <= i_redirect_target;
      r_inflight <= w_inflightNext;
      r_dropCnt  <= w_inflightNext;
      r_count    <= '0;
      r_rdPtr    <= '0;
      r_wrPtr    <= '0;
    end else begin
      if (w_accept) r_pc <= r_pc + 32'd4;
      r_inflight <= w_inflightNext;
      if (i_imem_resp_valid && (r_dropCnt != '0)) r_dropCnt <= r_dropCnt - IW'(1);
      if (w_push) begin
        r_respPc <= r_respPc + 32'd4;
        r_wrPtr  <= r_wrPtr + PW'(1);
      end
      if (w_pop) r_rdPtr <= r_rdPtr + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_qPc[r_wrPtr]   <= r_respPc;
      r_qInst[r_wrPtr] <= i_imem_resp_rdata;
    end
  end

  assign o_imem_req_valid = w_reqValid;
  assign o_imem_req_addr  = r_pc;
  assign o_inst_valid     = w_headValid;
  assign o_inst           = w_headValid ? r_qInst[r_rdPtr] : NOP;
  assign o_fetch_pc       = w_headValid ? r_qPc[r_rdPtr] : 32'd0;
  assign o_pc_plus_4      = o_fetch_pc + 32'd4;
  assign o_fq_count       = r_count;

  // Protocol violations by the memory side or a broken credit computation.
  assert property (@(posedge i_clk) disable iff (!i_rst_n)
    i_imem_resp_valid |-> (r_inflight != '0));
  assert property (@(posedge i_clk) disable iff (!i_rst_n)
    w_push |-> (r_count < CW'(FQ_DEPTH)));
  assert property (@(posedge i_clk) disable iff (!i_rst_n)
    r_dropCnt <= r_inflight);

endmodule
